// File: rtl/tmds_rx_decoder_if.sv
// rtl/tmds_rx_decoder_if.sv - serial TMDS lane in, decoded symbol stream and lock status out
interface tmds_rx_decoder_if;
  logic        sin;
  logic [7:0]  dout;
  logic [1:0]  ctl;
  logic        de;
  logic        valid;
  logic        locked;
  logic [15:0] lock_loss_cnt;

  modport master (input sin, output dout, ctl, de, valid, locked, lock_loss_cnt);
  modport slave  (output sin, input dout, ctl, de, valid, locked, lock_loss_cnt);
endinterface

// File: rtl/tmds_rx_decoder.sv
// rtl/tmds_rx_decoder.sv - TMDS lane aligner/decoder; optional lock-loss counter under TMDS_RX_LOCK_STATS_EN
module tmds_rx_decoder #(
  parameter int LOCK_COUNT   = 4,
  parameter int MAX_DATA_RUN = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  tmds_rx_decoder_if.master rx
);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int RUN_W   = $clog2(MAX_DATA_RUN + 1);
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0]   RUN_LAST  = RUN_W'(MAX_DATA_RUN - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t             state;
  logic [9:0]         q;
  logic [3:0]         phase;
  logic [MATCH_W-1:0] match_cnt;
  logic [RUN_W-1:0]   run_cnt;
  logic [7:0]         dout_r;
  logic [1:0]         ctl_r;
  logic               de_r;
  logic               valid_r;
  logic               locked_r;

  logic       boundary;
  logic       is_token;
  logic [1:0] tok_ctl;
  logic [7:0] d;
  logic [7:0] x;
  logic [7:0] data_byte;
  logic       drop;

  assign boundary = (phase == 4'd9);

  always_comb begin
    is_token = 1'b1;
    tok_ctl  = 2'b00;
    case (q)
      10'h354: tok_ctl = 2'b00;
      10'h0AB: tok_ctl = 2'b01;
      10'h154: tok_ctl = 2'b10;
      10'h2AB: tok_ctl = 2'b11;
      default: is_token = 1'b0;
    endcase
  end

  // x[i] = d[i]^d[i-1]; q[8] selects XOR vs XNOR chaining
  assign d         = q[9] ? ~q[7:0] : q[7:0];
  assign x         = d ^ {d[6:0], 1'b0};
  assign data_byte = {q[8] ? x[7:1] : ~x[7:1], d[0]};

  // Data symbol that would complete an over-long run: suppressed and lock abandoned
  assign drop = (state == LOCKED) && boundary && !is_token && (run_cnt == RUN_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= HUNT;
      q         <= '0;
      phase     <= '0;
      match_cnt <= '0;
      run_cnt   <= '0;
      dout_r    <= '0;
      ctl_r     <= '0;
      de_r      <= 1'b0;
      valid_r   <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      q       <= {rx.sin, q[9:1]};
      phase   <= boundary ? 4'd0 : phase + 4'd1;
      valid_r <= 1'b0;
      case (state)
        HUNT: begin
          if (is_token) begin
            // restart phase so the next boundary lands exactly one symbol later
            phase   <= 4'd0;
            run_cnt <= '0;
            if (LOCK_COUNT <= 1) begin
              state     <= LOCKED;
              locked_r  <= 1'b1;
              match_cnt <= '0;
            end else begin
              state     <= VERIFY;
              match_cnt <= MATCH_W'(1);
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (!is_token) begin
              state     <= HUNT;
              match_cnt <= '0;
            end else if (match_cnt == LOCK_LAST) begin
              state     <= LOCKED;
              locked_r  <= 1'b1;
              match_cnt <= '0;
              run_cnt   <= '0;
            end else begin
              match_cnt <= match_cnt + MATCH_W'(1);
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (is_token) begin
              ctl_r   <= tok_ctl;
              de_r    <= 1'b0;
              valid_r <= 1'b1;
              run_cnt <= '0;
            end else if (drop) begin
              state    <= HUNT;
              locked_r <= 1'b0;
              run_cnt  <= '0;
            end else begin
              dout_r  <= data_byte;
              de_r    <= 1'b1;
              valid_r <= 1'b1;
              run_cnt <= run_cnt + RUN_W'(1);
            end
          end
        end
        default: begin
          state    <= HUNT;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef TMDS_RX_LOCK_STATS_EN
  logic [15:0] loss_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      loss_cnt <= '0;
    end else if (drop && (loss_cnt != 16'hFFFF)) begin
      loss_cnt <= loss_cnt + 16'd1;
    end
  end

  assign rx.lock_loss_cnt = loss_cnt;
`else
  assign rx.lock_loss_cnt = 16'h0000;
`endif

  assign rx.dout   = dout_r;
  assign rx.ctl    = ctl_r;
  assign rx.de     = de_r;
  assign rx.valid  = valid_r;
  assign rx.locked = locked_r;
endmodule

// File: tb/tb_tmds_rx_decoder.sv
// tb/tb_tmds_rx_decoder.sv - randomized self-checking bench for tmds_rx_decoder
module tb_tmds_rx_decoder;
  localparam int MAX_RUN = 8;

  typedef struct {
    int         stamp;
    bit         de;
    logic [7:0] dout;
    logic [1:0] ctl;
  } strobe_t;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  int         cyc      = 0;
  int         n_chk    = 0;
  int         n_err    = 0;
  int         hold_err = 0;
  int         stray_err = 0;
  strobe_t    obs_q[$];
  strobe_t    exp_q[$];
  logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  int         m_run    = 0;
  bit         m_locked = 1'b0;
  int         m_loss   = 0;
  logic [10:0] prev_out = '0;
  logic        prev_rst = 1'b0;

  tmds_rx_decoder_if rx_if();

  tmds_rx_decoder #(.LOCK_COUNT(4), .MAX_DATA_RUN(MAX_RUN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.valid === 1'b1) begin
      obs_q.push_back('{cyc, rx_if.de, rx_if.dout, rx_if.ctl});
      if (rx_if.locked !== 1'b1) stray_err++;
    end else if (reset_n && prev_rst && ({rx_if.de, rx_if.ctl, rx_if.dout} !== prev_out)) begin
      hold_err++;
    end
    prev_out = {rx_if.de, rx_if.ctl, rx_if.dout};
    prev_rst = reset_n;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int tok_idx(input logic [9:0] s);
    for (int t = 0; t < 4; t++) if (s == tok[t]) return t;
    return -1;
  endfunction

  // inverse of the decode rule: builds a symbol that must decode back to b
  function automatic logic [9:0] enc(input logic [7:0] b, input bit q8, input bit q9);
    logic [7:0] dd;
    dd[0] = b[0];
    for (int i = 1; i < 8; i++) dd[i] = q8 ? (b[i] ^ dd[i-1]) : (~b[i] ^ dd[i-1]);
    return {q9, q8, q9 ? ~dd : dd};
  endfunction

  task automatic send_bits(input logic [9:0] s, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      rx_if.sin = s[i];
    end
  endtask

  task automatic expect_sym(input logic [9:0] s, input logic [7:0] bval, input int ret);
    int k;
    k = tok_idx(s);
    if (!m_locked) return;
    if (k >= 0) begin
      exp_q.push_back('{ret + 2, 1'b0, 8'h00, 2'(k)});
      m_run = 0;
    end else if (m_run + 1 == MAX_RUN) begin
      m_locked = 1'b0;
      m_loss++;
      m_run = 0;
    end else begin
      m_run++;
      exp_q.push_back('{ret + 2, 1'b1, bval, 2'b00});
    end
  endtask

  task automatic send_sym(input logic [9:0] s, input logic [7:0] bval);
    send_bits(s, 0, 9);
    expect_sym(s, bval, cyc);
  endtask

  task automatic send_data(input logic [7:0] b);
    logic [9:0] s;
    do s = enc(b, 1'($urandom), 1'($urandom)); while (tok_idx(s) >= 0);
    send_sym(s, b);
  endtask

  task automatic drain();
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      strobe_t o;
      strobe_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("strobe_cycle", o.stamp, e.stamp);
      check("strobe_de", o.de, e.de);
      if (e.de) check("strobe_dout", o.dout, e.dout);
      else      check("strobe_ctl", o.ctl, e.ctl);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dout"},   rx_if.dout, 0);
    check({tag, "_ctl"},    rx_if.ctl, 0);
    check({tag, "_de"},     rx_if.de, 0);
    check({tag, "_valid"},  rx_if.valid, 0);
    check({tag, "_locked"}, rx_if.locked, 0);
    check({tag, "_loss"},   rx_if.lock_loss_cnt, 0);
  endtask

  // offset zeros, four aligned 0x354 tokens, then the first symbol after lock
  task automatic acquire(input int offset, input logic [9:0] nxt, input logic [7:0] nbyte);
    for (int i = 0; i < offset; i++) send_bits(10'h000, 0, 0);
    for (int t = 0; t < 4; t++) begin
      send_bits(10'h354, 0, 9);
      check("acq_unlocked", rx_if.locked, 1'b0);
    end
    send_bits(nxt, 0, 0);
    check("lock_boundary_cycle", rx_if.locked, 1'b0);
    send_bits(nxt, 1, 1);
    check("lock_declared", rx_if.locked, 1'b1);
    check("acq_no_valid", obs_q.size(), 0);
    m_locked = 1'b1;
    m_run    = 0;
    send_bits(nxt, 2, 9);
    expect_sym(nxt, nbyte, cyc);
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk);
    #1 reset_n = 1'b0;
    rx_if.sin = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset_n = 1'b1;
    m_locked = 1'b0;
    m_run    = 0;
    m_loss   = 0;
  endtask

  initial begin
    int exp_loss;
    rx_if.sin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    acquire(3, 10'h100, 8'h00);
    send_sym(10'h2FF, 8'hFE);
    send_sym(10'h0AB, 8'h00);
    send_sym(10'h154, 8'h00);
    send_sym(10'h2AB, 8'h00);
    drain();

    for (int n = 0; n < 40; n++) begin
      if (m_run == MAX_RUN - 1 || $urandom_range(0, 3) == 0) send_sym(tok[$urandom_range(0, 3)], 8'h00);
      else send_data(8'($urandom));
    end
    check("rand_locked", rx_if.locked, 1'b1);
    drain();

    send_sym(10'h354, 8'h00);
    for (int n = 0; n < MAX_RUN; n++) send_data(8'($urandom));
    send_bits(10'h000, 0, 0);
    check("run_limit_boundary_locked", rx_if.locked, 1'b1);
    send_bits(10'h000, 0, 0);
    check("run_limit_unlocked", rx_if.locked, 1'b0);
`ifdef TMDS_RX_LOCK_STATS_EN
    exp_loss = m_loss;
`else
    exp_loss = 0;
`endif
    check("lock_loss_cnt", rx_if.lock_loss_cnt, exp_loss);
    send_bits(10'h000, 0, 9);
    send_bits(10'h000, 0, 9);
    check("run_limit_stays_unlocked", rx_if.locked, 1'b0);
    drain();
    check("run_limit_obs_left", obs_q.size(), 0);
    check("run_limit_exp_left", exp_q.size(), 0);

    pulse_reset(2);
    send_bits(10'h000, 0, 4);
    send_sym(10'h354, 8'h00);
    send_sym(10'h354, 8'h00);
    send_sym(10'h100, 8'h00);
    check("verify_fail_unlocked", rx_if.locked, 1'b0);
    acquire(0, 10'h2FF, 8'hFE);
    send_sym(10'h0AB, 8'h00);
    send_bits(10'h100, 0, 4);
    drain();
    check("pre_reset_obs_left", obs_q.size(), 0);
    check("pre_reset_exp_left", exp_q.size(), 0);

    pulse_reset(1);
    @(negedge clk);
    check_zero_outputs("midsym_reset");
    acquire(5, 10'h154, 8'h00);
    send_data(8'($urandom));
    send_sym(10'h2AB, 8'h00);
    send_bits(10'h000, 0, 2);
    drain();
    check("final_obs_left", obs_q.size(), 0);
    check("final_exp_left", exp_q.size(), 0);
    check("hold_violations", hold_err, 0);
    check("valid_while_unlocked", stray_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tmds_rx_decoder.md
TMDS_RX_DECODER -- requirements
Module: tmds_rx_decoder

Interface
REQ-001 Parameter: LOCK_COUNT, default 4, consecutive boundary-aligned control tokens required to declare lock.
REQ-002 Parameter: MAX_DATA_RUN, default 4096, consecutive data symbols tolerated before lock is dropped.
REQ-003 Port: clk  input  1  bit-rate clock, one serial TMDS bit per rising edge.
REQ-004 Port: reset_n  input  1  synchronous, active-low reset.
REQ-005 Port: sin  input  1  serial TMDS lane, LSB (q[0]) first.
REQ-006 Port: dout  output  8  decoded pixel byte, valid when de=1.
REQ-007 Port: ctl  output  2  decoded control bits, valid when de=0.
REQ-008 Port: de  output  1  1 = data symbol, 0 = control token.
REQ-009 Port: valid  output  1  one-cycle strobe per decoded symbol.
REQ-010 Port: locked  output  1  symbol alignment established.
REQ-011 Port: lock_loss_cnt  output  16  count of LOCKED->HUNT transitions.

Function
REQ-012 The block shall shift sin into a 10-bit register each cycle, with the oldest bit at q[0] and the newest bit at q[9].
REQ-013 Control tokens (q[9:0]) shall be: 10'h354->ctl 00; 10'h0AB->ctl 01; 10'h154->ctl 10; 10'h2AB->ctl 11.
REQ-014 Data decode: d = q[9] ? ~q[7:0] : q[7:0]; dout[0]=d[0]; for i=1..7, dout[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-015 States shall be HUNT, VERIFY and LOCKED.
REQ-016 A 4-bit phase counter shall wrap 9->0; a symbol boundary is a cycle with phase=9.
REQ-017 HUNT: the window is compared every cycle; on a token match -> VERIFY, match count=1, phase reloaded so that the next boundary occurs 10 cycles later.
REQ-018 VERIFY: at each boundary, a token match increments the match count; reaching LOCK_COUNT -> LOCKED; a non-token -> HUNT with count cleared.
REQ-019 LOCKED: at each boundary, dout/ctl/de shall be registered and valid pulsed high in the following cycle, giving 1-cycle latency after the edge that shifts in q[9].
REQ-020 The first valid after lock shall occur at the boundary following the lock-declaring boundary.
REQ-021 The data-run counter shall clear on any token and increment on each data symbol.
REQ-022 When the data-run counter would reach MAX_DATA_RUN, that symbol shall not be output (valid stays 0), the block shall go to HUNT, and locked shall drop next cycle.
REQ-023 locked shall be high only in LOCKED.
REQ-024 valid shall never assert outside LOCKED.
REQ-025 Between strobes, dout, ctl and de shall hold their last values.
REQ-026 Non-token symbols in LOCKED shall always decode as data; no code-error flagging.
REQ-027 lock_loss_cnt shall saturate at 16'hFFFF and not wrap.

Reset
REQ-028 While reset_n=0 at a clk edge: state=HUNT, phase=0, shift register=0, counters=0.
REQ-029 While reset_n=0 at a clk edge: dout=0, ctl=0, de=0, valid=0, locked=0, lock_loss_cnt=0.
REQ-030 A reset asserted mid-symbol or mid-VERIFY shall discard partial state; no valid strobe follows until lock is reacquired.
REQ-031 The reset path shall have no asynchronous term.

Configuration
REQ-032 Macro TMDS_RX_LOCK_STATS_EN defined: lock_loss_cnt shall be implemented per REQ-011 and REQ-027.
REQ-033 Macro TMDS_RX_LOCK_STATS_EN undefined: lock_loss_cnt shall be tied to 16'h0000, no counter logic shall be built, and all other behaviour shall be unchanged.

Verification
REQ-034 After reset, 10'h354 sent 4 times with a 3-bit leading offset -> locked=1 one cycle after the 4th token boundary; valid=0 throughout acquisition.
REQ-035 Locked, then 10'h100 then 10'h2FF sent -> valid strobes 10 cycles apart, dout=8'h00 de=1, then dout=8'hFE de=1.
REQ-036 Locked, tokens 10'h0AB, 10'h154, 10'h2AB sent -> de=0 with ctl=01, 10, 11 respectively, one strobe each.
REQ-037 VERIFY after 2 tokens, then one 10'h100 at the boundary -> back to HUNT, locked stays 0, and a further 4 tokens are needed to lock.
REQ-038 With MAX_DATA_RUN=8, locked stream of 8 data symbols -> 7 valid strobes, locked drops, lock_loss_cnt increments 0->1 (macro defined) or stays 0 (undefined).
REQ-039 reset_n pulsed low for 1 cycle mid-symbol while LOCKED -> all outputs 0 next cycle and no valid until 4 fresh tokens.
